// File: rtl/alu_exec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_pkg                                              |
// | Purpose  : Shared types for the ALU execution unit: opcode encoding, |
// |            the {O,C,Z,N} flag record and the control FSM states.     |
// | Config   : ALU_EXEC_MUL_EN enables opcode 9 (MUL) in the datapath.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_exec_pkg;

  // Opcodes 10..15 have no enum member; they are decoded as illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_LDI = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  // Packed so that it maps directly onto the 4-bit {O,C,Z,N} response field.
  typedef struct packed {
    logic o;
    logic c;
    logic z;
    logic n;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_datapath                                         |
// | Purpose  : Purely combinational ALU. Computes result, flags and an   |
// |            illegal-opcode indication from op, A, B and immediate.    |
// | Ports    : op_i[3:0], a_i/b_i/imm_i[WIDTH-1:0] in;                   |
// |            result_o[WIDTH-1:0], flags_o (flags_t), illegal_o out.    |
// | Config   : ALU_EXEC_MUL_EN - when defined, op 9 is an unsigned MUL;  |
// |            otherwise op 9 is illegal.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_exec_datapath
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] result_o,
  output flags_t           flags_o,
  output logic             illegal_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [SHW-1:0]   shamt_w;

  assign sum_w   = {1'b0, a_i} + {1'b0, b_i};
  // Subtraction as A + ~B + 1 so the carry-out means "no borrow".
  assign diff_w  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt_w = b_i[SHW-1:0];

`ifdef ALU_EXEC_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
`endif

  always_comb begin
    result_o  = '0;
    flags_o   = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o  = sum_w[WIDTH-1:0];
        flags_o.c = sum_w[WIDTH];
        // Overflow: operands share a sign and the result sign differs.
        flags_o.o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                    (sum_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o  = diff_w[WIDTH-1:0];
        flags_o.c = diff_w[WIDTH];
        // Overflow: operand signs differ and the result sign differs from A.
        flags_o.o = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                    (diff_w[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SHL: result_o = a_i << shamt_w;
      OP_SHR: result_o = a_i >> shamt_w;
      OP_LDI: result_o = imm_i;
`ifdef ALU_EXEC_MUL_EN
      OP_MUL: begin
        result_o  = prod_w[WIDTH-1:0];
        flags_o.c = |prod_w[2*WIDTH-1:WIDTH];
      end
`endif
      default: illegal_o = 1'b1;
    endcase
    // Z/N come from whatever result was chosen; illegal ops force result 0
    // and the top substitutes the held flag register anyway.
    flags_o.z = (result_o == '0);
    flags_o.n = result_o[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_exec_unit                                             |
// | Purpose  : Handshaked ALU execution unit with an internal register   |
// |            file. Serial FSM IDLE->READ->EXEC->RESP; results are      |
// |            written back and returned with registered {O,C,Z,N}.      |
// | Ports    : clk, rst_n (async, active-low)                            |
// |            cmd_valid_i/cmd_ready_o, cmd_op_i, cmd_rd_i/ra_i/rb_i,    |
// |            cmd_imm_i       - command channel                         |
// |            rsp_valid_o/rsp_ready_i, rsp_data_o, rsp_flags_o,         |
// |            rsp_err_o       - response channel                        |
// |            dbg_addr_i/dbg_data_o - combinational register peek       |
// | Config   : ALU_EXEC_MUL_EN enables opcode 9 (unsigned MUL).          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NREGS  = 8,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [REG_AW-1:0] cmd_rd_i,
  input  logic [REG_AW-1:0] cmd_ra_i,
  input  logic [REG_AW-1:0] cmd_rb_i,
  input  logic [WIDTH-1:0]  cmd_imm_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WIDTH-1:0]  rsp_data_o,
  output logic [3:0]        rsp_flags_o,
  output logic              rsp_err_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]  dbg_data_o
);

  state_e              state_q, state_d;
  logic                accept_w;

  logic [3:0]          op_q;
  logic [REG_AW-1:0]   rd_q, ra_q, rb_q;
  logic [WIDTH-1:0]    imm_q;
  logic [WIDTH-1:0]    a_q, b_q;

  logic [WIDTH-1:0]    regs_q [NREGS];
  flags_t              flags_q;

  logic [WIDTH-1:0]    rsp_data_q;
  flags_t              rsp_flags_q;
  logic                rsp_err_q;

  logic [WIDTH-1:0]    dp_result_w;
  flags_t              dp_flags_w;
  logic                dp_illegal_w;
  logic                exec_w;

  alu_exec_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .op_i      (op_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .imm_i     (imm_q),
    .result_o  (dp_result_w),
    .flags_o   (dp_flags_w),
    .illegal_o (dp_illegal_w)
  );

  // --------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept_w    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept_w = 1'b1;
          state_d  = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign exec_w = (state_q == EXEC);

  // --------------------------------------------------------------------
  // Command and operand capture
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      rd_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
    end else if (accept_w) begin
      op_q  <= cmd_op_i;
      rd_q  <= cmd_rd_i;
      ra_q  <= cmd_ra_i;
      rb_q  <= cmd_rb_i;
      imm_q <= cmd_imm_i;
    end
  end

  // Register 0 is never written, so reading it here already yields zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == READ) begin
      a_q <= regs_q[ra_q];
      b_q <= regs_q[rb_q];
    end
  end

  // --------------------------------------------------------------------
  // Register file and flag register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (exec_w && !dp_illegal_w && (rd_q != '0)) begin
      regs_q[rd_q] <= dp_result_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (exec_w && !dp_illegal_w) begin
      flags_q <= dp_flags_w;
    end
  end

  // --------------------------------------------------------------------
  // Response registers: loaded once in EXEC, held through RESP.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (exec_w) begin
      rsp_data_q  <= dp_result_w;
      rsp_flags_q <= dp_illegal_w ? flags_q : dp_flags_w;
      rsp_err_q   <= dp_illegal_w;
    end
  end

  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o   = rsp_err_q;
  assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_exec_unit                                          |
// | Purpose  : Self-checking bench. Drives a 32-bit/8-register unit and  |
// |            an 8-bit/4-register unit in lockstep from one command     |
// |            stream and compares both against an arithmetic model.     |
// | Config   : honours ALU_EXEC_MUL_EN the same way as the design.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic [31:0] cmd_imm;
  logic        rsp_ready;
  logic [2:0]  dbg_addr;

  logic        cmd_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_data_a, dbg_data_a;
  logic [3:0]  rsp_flags_a;

  logic        cmd_ready_b, rsp_valid_b, rsp_err_b;
  logic [7:0]  rsp_data_b, dbg_data_b;
  logic [3:0]  rsp_flags_b;

  alu_exec_unit #(.WIDTH(32), .NREGS(8)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_a),
    .cmd_op_i    (cmd_op),
    .cmd_rd_i    (cmd_rd),
    .cmd_ra_i    (cmd_ra),
    .cmd_rb_i    (cmd_rb),
    .cmd_imm_i   (cmd_imm),
    .rsp_valid_o (rsp_valid_a),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data_a),
    .rsp_flags_o (rsp_flags_a),
    .rsp_err_o   (rsp_err_a),
    .dbg_addr_i  (dbg_addr),
    .dbg_data_o  (dbg_data_a)
  );

  alu_exec_unit #(.WIDTH(8), .NREGS(4)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_b),
    .cmd_op_i    (cmd_op),
    .cmd_rd_i    (cmd_rd[1:0]),
    .cmd_ra_i    (cmd_ra[1:0]),
    .cmd_rb_i    (cmd_rb[1:0]),
    .cmd_imm_i   (cmd_imm[7:0]),
    .rsp_valid_o (rsp_valid_b),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data_b),
    .rsp_flags_o (rsp_flags_b),
    .rsp_err_o   (rsp_err_b),
    .dbg_addr_i  (dbg_addr[1:0]),
    .dbg_data_o  (dbg_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 3000000);
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state for both widths.
  logic [31:0] m32 [8];
  logic [7:0]  m8  [4];
  logic [3:0]  f32, f8;

  logic [31:0] cap_data_a;
  logic [3:0]  cap_flags_a;
  logic [7:0]  cap_data_b;
  logic [3:0]  cap_flags_b;
  int          last_rd;
  int          last_wait;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m32[i] = '0;
    for (int i = 0; i < 4; i++) m8[i] = '0;
    f32 = '0;
    f8  = '0;
  endtask

  // Arithmetic model of one operation for width w (power of two, <= 32).
  function automatic void ref_op(input int w, input logic [3:0] op,
                                 input longint unsigned a, input longint unsigned b,
                                 input longint unsigned imm, input logic [3:0] cur,
                                 output longint unsigned res, output logic [3:0] fl,
                                 output logic err);
    longint unsigned mask, full;
    longint sa, sb, sr, smax, smin;
    logic o, c;
    mask = (64'd1 << w) - 64'd1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa = (((a >> (w - 1)) & 1) != 0) ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = (((b >> (w - 1)) & 1) != 0) ? longint'(b) - (longint'(1) << w) : longint'(b);
    o = 1'b0; c = 1'b0; err = 1'b0; res = 0;
    case (op)
      4'd0: begin
        full = a + b; res = full & mask; c = (full >> w) != 0;
        sr = sa + sb; o = (sr > smax) || (sr < smin);
      end
      4'd1: begin
        res = (a - b) & mask; c = (a >= b);
        sr = sa - sb; o = (sr > smax) || (sr < smin);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = (sa < sb) ? 1 : 0;
      4'd6: res = (a << (b % w)) & mask;
      4'd7: res = a >> (b % w);
      4'd8: res = imm & mask;
`ifdef ALU_EXEC_MUL_EN
      4'd9: begin
        full = a * b; res = full & mask; c = (full >> w) != 0;
      end
`endif
      default: err = 1'b1;
    endcase
    if (err) begin
      res = 0;
      fl  = cur;
    end else begin
      fl = {o, c, (res == 0), (((res >> (w - 1)) & 1) != 0)};
    end
  endfunction

  // Presents a command at a negedge, waits for accept and the response,
  // checks it and leaves the response pending (handshake not completed).
  task automatic send(input logic [3:0] op, input int rd, input int ra, input int rb,
                      input logic [31:0] imm);
    longint unsigned r32, r8;
    logic [3:0] e_f32, e_f8;
    logic e_err32, e_err8;
    int k, lat;
    cmd_op = op; cmd_rd = rd[2:0]; cmd_ra = ra[2:0]; cmd_rb = rb[2:0];
    cmd_imm = imm; cmd_valid = 1'b1;
    ref_op(32, op, m32[ra], m32[rb], imm, f32, r32, e_f32, e_err32);
    ref_op(8, op, m8[ra & 3], m8[rb & 3], imm & 32'hFF, f8, r8, e_f8, e_err8);
    k = 0;
    while (!cmd_ready_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("accept_timeout", 1'b0, 1'b1);
    last_wait = k;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("ready_busy", cmd_ready_a, 1'b0);
    check("valid_b", rsp_valid_b, 1'b1);
    check("data_a", rsp_data_a, r32);
    check("flags_a", rsp_flags_a, e_f32);
    check("err_a", rsp_err_a, e_err32);
    check("data_b", rsp_data_b, r8);
    check("flags_b", rsp_flags_b, e_f8);
    check("err_b", rsp_err_b, e_err8);
    cap_data_a = rsp_data_a; cap_flags_a = rsp_flags_a;
    cap_data_b = rsp_data_b; cap_flags_b = rsp_flags_b;
    if (!e_err32) begin
      if (rd != 0) m32[rd] = r32[31:0];
      f32 = e_f32;
    end
    if (!e_err8) begin
      if ((rd & 3) != 0) m8[rd & 3] = r8[7:0];
      f8 = e_f8;
    end
    last_rd = rd;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_idle_a", cmd_ready_a, 1'b1);
    check("ready_idle_b", cmd_ready_b, 1'b1);
    check("valid_drop", rsp_valid_a, 1'b0);
    dbg_addr = last_rd[2:0];
    #1;
    check("dbg_a", dbg_data_a, m32[last_rd]);
    check("dbg_b", dbg_data_b, m8[last_rd & 3]);
  endtask

  task automatic do_op(input logic [3:0] op, input int rd, input int ra, input int rb,
                       input logic [31:0] imm);
    send(op, rd, ra, rb, imm);
    finish_rsp();
  endtask

  logic [31:0] hold_data;
  logic [3:0]  prev_f32;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
    cmd_rb = '0; cmd_imm = '0; rsp_ready = 1'b1; dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready", cmd_ready_a, 1'b1);
    check("rst_valid", rsp_valid_a, 1'b0);
    check("rst_data", rsp_data_a, 32'h0);
    check("rst_flags", rsp_flags_a, 4'h0);
    check("rst_err", rsp_err_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      check("rst_reg", dbg_data_a, 32'h0);
    end

    // Signed overflow on ADD
    do_op(4'd8, 1, 0, 0, 32'h7FFF_FFFF);
    do_op(4'd8, 2, 0, 0, 32'h1);
    do_op(4'd0, 3, 1, 2, 32'h0);
    check("add_ovf_data", cap_data_a, 32'h8000_0000);
    check("add_ovf_flags", cap_flags_a, 4'b1001);
    dbg_addr = 3'd3;
    #1;
    check("add_ovf_dbg", dbg_data_a, 32'h8000_0000);

    // SUB equal operands and borrow
    do_op(4'd8, 1, 0, 0, 32'd5);
    do_op(4'd1, 4, 1, 1, 32'h0);
    check("sub_zero_data", cap_data_a, 32'h0);
    check("sub_zero_flags", cap_flags_a, 4'b0110);
    do_op(4'd1, 5, 0, 1, 32'h0);
    check("sub_borrow_data", cap_data_a, 32'hFFFF_FFFB);
    check("sub_borrow_flags", cap_flags_a, 4'b0001);

    // Write to r0 is dropped but still reported
    do_op(4'd8, 0, 0, 0, 32'h1234);
    check("r0_data", cap_data_a, 32'h1234);
    dbg_addr = 3'd0;
    #1;
    check("r0_dbg", dbg_data_a, 32'h0);

    // 8-bit overflow cases on the narrow instance
    do_op(4'd8, 1, 0, 0, 32'h7F);
    do_op(4'd8, 2, 0, 0, 32'h1);
    do_op(4'd0, 3, 1, 2, 32'h0);
    check("add8_data", cap_data_b, 8'h80);
    check("add8_flags", cap_flags_b, 4'b1001);
    do_op(4'd8, 1, 0, 0, 32'h80);
    do_op(4'd1, 3, 1, 2, 32'h0);
    check("sub8_data", cap_data_b, 8'h7F);
    check("sub8_flags", cap_flags_b, 4'b1100);

    // Back-pressure: hold the response, offer a second command meanwhile
    rsp_ready = 1'b0;
    send(4'd4, 6, 1, 2, 32'h0);
    hold_data = cap_data_a;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'd2; cmd_rd = 3'd7; cmd_ra = 3'd1; cmd_rb = 3'd2;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rsp_valid_a, 1'b1);
      check("hold_data", rsp_data_a, hold_data);
      check("hold_ready", cmd_ready_a, 1'b0);
    end
    finish_rsp();
    send(4'd2, 7, 1, 2, 32'h0);
    check("accept_next", last_wait, 0);
    finish_rsp();

    // Illegal opcode keeps flags and destination
    prev_f32 = f32;
    do_op(4'd12, 3, 1, 2, 32'h0);
    check("ill_err", cap_data_a == 32'h0 && rsp_err_a, 1'b1);
    check("ill_flags", cap_flags_a, prev_f32);

    // Opcode 9
    do_op(4'd8, 1, 0, 0, 32'h0001_0000);
    send(4'd9, 2, 1, 1, 32'h0);
`ifdef ALU_EXEC_MUL_EN
    check("mul_data", cap_data_a, 32'h0);
    check("mul_flags", cap_flags_a, 4'b0110);
`else
    check("mul_illegal", rsp_err_a, 1'b1);
`endif
    finish_rsp();

    // Randomized commands
    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom);
    end

    // Reset while the ADD r6 command sits in EXEC
    do_op(4'd8, 1, 0, 0, 32'd3);
    do_op(4'd8, 2, 0, 0, 32'd4);
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 3'd6; cmd_ra = 3'd1; cmd_rb = 3'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_valid", rsp_valid_a, 1'b0);
      check("abort_ready", cmd_ready_a, 1'b1);
    end
    dbg_addr = 3'd6;
    #1;
    check("abort_r6", dbg_data_a, 32'h0);
    do_op(4'd8, 6, 0, 0, 32'd9);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
